sig_measure_core: RTL and testbench
===================================

// Module: sig_measure_core
// PURPOSE
//  Measurement core of the frequency meter: two edge-rate counters, an input-to-input phase
//  counter and a high/low duty counter, all in sys_clk cycles. Sits between the two raw
//  signal pins and the SPI framing logic, which reads the five 32-bit result buffers.
//  Buffers hold the last completed measurement; no handshake is provided.
// PARAMETERS
//  GATE_CYCLES  100_000_000  gate window length in sys_clk cycles (1 s at 100 MHz), >=2
//  PHASE_AVG    4            phase measurements summed per phase_diff_cnt_buf update
// PORTS
//  sys_clk              in   1   system clock; all logic on rising edge
//  rst_n                in   1   asynchronous active-low reset
//  sig_in0              in   1   asynchronous measured signal 0 (phase reference)
//  sig_in1              in   1   asynchronous measured signal 1 (phase lagging, duty source)
//  sig_freq_cnt_buf1    out  32  rising edges of sig_in0 in last gate window
//  sig_freq_cnt_buf2    out  32  rising edges of sig_in1 in last gate window
//  phase_diff_cnt_buf   out  32  sum of PHASE_AVG in0->in1 edge delays (cycles)
//  sig_in_high_cnt_buf  out  32  cycles sig_in1 sampled high in last gate window
//  sig_in_low_cnt_buf   out  32  cycles sig_in1 sampled low in last gate window
// BEHAVIOUR
//  - Reset (async, rst_n=0): all outputs, counters, accumulators, gate timer and edge
//    registers clear to 0; phase state idle. Gate restarts at 0 on release.
//  - Input stage: each input registered twice (s0,s1); rise = s0 & ~s1; level = s0.
//  - Gate timer: counts 0..GATE_CYCLES-1, wraps; gate_tick when value == GATE_CYCLES-1.
//  - Freq (per input): edge_cnt += rise each cycle. On gate_tick: buf <= edge_cnt + rise,
//    edge_cnt <= 0. Counter saturates at 32'hFFFF_FFFF, never wraps.
//  - Duty (sig_in1): level ? high_cnt++ : low_cnt++. On gate_tick both bufs latch
//    count incl. current cycle, counters clear; high+low buffers == GATE_CYCLES always.
//  - Phase: states IDLE, RUN. rise0 -> RUN, delay <= 0 (restart if already RUN; prior
//    incomplete measurement discarded). RUN: delay++ per cycle (saturating). rise1 in
//    RUN: acc += delay+1, n++, -> IDLE. Value recorded = cycles from rise0 to rise1.
//    rise1 in IDLE ignored. rise0 & rise1 same cycle: record 0, n++, stay IDLE.
//    When n reaches PHASE_AVG: phase_diff_cnt_buf <= acc (incl. this sample), acc, n <= 0.
//    acc saturates at 32'hFFFF_FFFF. Downstream divides by PHASE_AVG.
//  - Buffers update one cycle after the triggering event; stable between updates.
//  - Gate and phase paths independent; gate_tick coincident with phase completion
//    updates both in the same cycle.
// CONFIGURATION
//  INPUT_SYNC_EN defined: two extra flops per input ahead of s0/s1 (metastability
//    guard); edge/level latency 4 cycles. Counts over periodic signals unchanged.
//  INPUT_SYNC_EN undefined: only s0/s1; latency 2 cycles.
// TESTING (GATE_CYCLES=1000, PHASE_AVG=4)
//  1 sig_in0 period 10 (5H/5L) -> sig_freq_cnt_buf1 == 100 from 2nd gate on; buf2 == 0.
//  2 sig_in1 period 10, 3H/7L -> high_buf == 300, low_buf == 700, freq_buf2 == 100.
//  3 both period 20, in1 rises 5 cycles after in0 -> phase_diff_cnt_buf == 20 after 4 pairs.
//  4 in0/in1 identical waveform -> phase_diff_cnt_buf == 0; freq bufs equal.
//  5 sig_in1 held low -> freq_buf2 == 0, high_buf == 0, low_buf == 1000.
//  6 rst_n low mid-gate -> all outputs 0 asynchronously; first update 1000 cycles after release.

Source files
------------

// File: rtl/sig_measure_core.sv
// sig_measure_core: measurement core of the frequency meter.
//   Counts rising edges of two asynchronous inputs over a gate window, the high/low duty of
//   sig_in1 over the same window, and the sum of PHASE_AVG sig_in0->sig_in1 edge delays.
//   All results are in sys_clk cycles, held in 32-bit buffers until the next update.
// Parameters:
//   GATE_CYCLES  gate window length in sys_clk cycles (>= 2)
//   PHASE_AVG    phase samples summed per phase_diff_cnt_buf update
// Ports:
//   sys_clk, rst_n          clock (rising edge), asynchronous active-low reset
//   sig_in0, sig_in1        asynchronous measured inputs (in0 = phase reference)
//   sig_freq_cnt_buf1/2     rising edges of sig_in0/sig_in1 in the last gate window
//   phase_diff_cnt_buf      sum of the last PHASE_AVG in0->in1 delays
//   sig_in_high_cnt_buf     cycles sig_in1 sampled high in the last gate window
//   sig_in_low_cnt_buf      cycles sig_in1 sampled low in the last gate window
// Build option:
//   INPUT_SYNC_EN  adds two metastability flops per input ahead of the edge detector.
module sig_measure_core #(
    parameter int unsigned GATE_CYCLES = 100_000_000,
    parameter int unsigned PHASE_AVG   = 4
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        sig_in0,
    input  logic        sig_in1,
    output logic [31:0] sig_freq_cnt_buf1,
    output logic [31:0] sig_freq_cnt_buf2,
    output logic [31:0] phase_diff_cnt_buf,
    output logic [31:0] sig_in_high_cnt_buf,
    output logic [31:0] sig_in_low_cnt_buf
);

`ifdef INPUT_SYNC_EN
    localparam int unsigned SyncStages = 4;
`else
    localparam int unsigned SyncStages = 2;
`endif

    typedef enum logic {StIdle, StRun} phase_st_e;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    // Input stage: the last two taps are s0 (newer) and s1 (older).
    logic [SyncStages-1:0] sync0_q, sync1_q;
    logic                  rise0, rise1, level1;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0_q <= '0;
            sync1_q <= '0;
        end else begin
            sync0_q <= {sync0_q[SyncStages-2:0], sig_in0};
            sync1_q <= {sync1_q[SyncStages-2:0], sig_in1};
        end
    end

    assign rise0  = sync0_q[SyncStages-2] & ~sync0_q[SyncStages-1];
    assign rise1  = sync1_q[SyncStages-2] & ~sync1_q[SyncStages-1];
    assign level1 = sync1_q[SyncStages-2];

    // Gate timer and per-window counters.
    logic [31:0] gate_q;
    logic        gate_tick;
    logic [31:0] edge0_q, edge1_q, high_q, low_q;
    logic [31:0] edge0_d, edge1_d, high_d, low_d;

    assign gate_tick = (gate_q == GATE_CYCLES - 1);

    // Next counts include the current cycle, so they are also what the buffers latch.
    always_comb begin
        edge0_d = sat_add(edge0_q, {31'b0, rise0});
        edge1_d = sat_add(edge1_q, {31'b0, rise1});
        high_d  = sat_add(high_q, {31'b0, level1});
        low_d   = sat_add(low_q, {31'b0, ~level1});
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_q              <= '0;
            edge0_q             <= '0;
            edge1_q             <= '0;
            high_q              <= '0;
            low_q               <= '0;
            sig_freq_cnt_buf1   <= '0;
            sig_freq_cnt_buf2   <= '0;
            sig_in_high_cnt_buf <= '0;
            sig_in_low_cnt_buf  <= '0;
        end else if (gate_tick) begin
            gate_q              <= '0;
            edge0_q             <= '0;
            edge1_q             <= '0;
            high_q              <= '0;
            low_q               <= '0;
            sig_freq_cnt_buf1   <= edge0_d;
            sig_freq_cnt_buf2   <= edge1_d;
            sig_in_high_cnt_buf <= high_d;
            sig_in_low_cnt_buf  <= low_d;
        end else begin
            gate_q  <= gate_q + 32'd1;
            edge0_q <= edge0_d;
            edge1_q <= edge1_d;
            high_q  <= high_d;
            low_q   <= low_d;
        end
    end

    // Phase measurement: delay_q counts cycles since rise0, so a rise1 records delay_q + 1.
    phase_st_e   phase_st_q;
    logic [31:0] delay_q, acc_q, n_q;
    logic        sample_vld, n_last;
    logic [31:0] sample, acc_sum;

    always_comb begin
        // Coincident edges record 0 whatever the state.
        sample_vld = rise1 & (rise0 | (phase_st_q == StRun));
        sample     = rise0 ? 32'd0 : sat_add(delay_q, 32'd1);
        acc_sum    = sat_add(acc_q, sample);
        n_last     = (n_q == PHASE_AVG - 1);
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_st_q         <= StIdle;
            delay_q            <= '0;
            acc_q              <= '0;
            n_q                <= '0;
            phase_diff_cnt_buf <= '0;
        end else begin
            if (sample_vld) begin
                if (n_last) begin
                    phase_diff_cnt_buf <= acc_sum;
                    acc_q              <= '0;
                    n_q                <= '0;
                end else begin
                    acc_q <= acc_sum;
                    n_q   <= n_q + 32'd1;
                end
            end
            // A new rise0 restarts the measurement, discarding any one in flight.
            if (rise0 && !rise1) begin
                phase_st_q <= StRun;
                delay_q    <= '0;
            end else if (sample_vld) begin
                phase_st_q <= StIdle;
            end else if (phase_st_q == StRun) begin
                delay_q <= sat_add(delay_q, 32'd1);
            end
        end
    end

endmodule

// File: tb/tb_sig_measure_core.sv
module tb_sig_measure_core;

    localparam int unsigned Gate = 1000;

    logic        clk;
    logic        rst_n;
    logic        sig_in0, sig_in1;
    logic [31:0] f1, f2, ph, hi, lo;

    sig_measure_core #(
        .GATE_CYCLES(Gate),
        .PHASE_AVG  (4)
    ) u_dut (
        .sys_clk            (clk),
        .rst_n              (rst_n),
        .sig_in0            (sig_in0),
        .sig_in1            (sig_in1),
        .sig_freq_cnt_buf1  (f1),
        .sig_freq_cnt_buf2  (f2),
        .phase_diff_cnt_buf (ph),
        .sig_in_high_cnt_buf(hi),
        .sig_in_low_cnt_buf (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // Waveform generator: periodic, high for hi cycles, shifted right by off cycles.
    int unsigned tcyc = 0;
    bit          en0 = 0, en1 = 0;
    int unsigned per0 = 10, hi0 = 5, off0 = 0;
    int unsigned per1 = 10, hi1 = 5, off1 = 0;

    initial begin
        sig_in0 = 1'b0;
        sig_in1 = 1'b0;
        forever begin
            @(negedge clk);
            tcyc++;
            sig_in0 = en0 && (((tcyc + per0 - off0) % per0) < hi0);
            sig_in1 = en1 && (((tcyc + per1 - off1) % per1) < hi1);
        end
    end

    task automatic set_sig(input bit e0, input int unsigned p0, input int unsigned h0,
                           input int unsigned o0, input bit e1, input int unsigned p1,
                           input int unsigned h1, input int unsigned o1);
        en0 = e0; per0 = p0; hi0 = h0; off0 = o0;
        en1 = e1; per1 = p1; hi1 = h1; off1 = o1;
    endtask

    // Independent gate-edge count: the buffers refresh on every multiple of Gate.
    int unsigned gcnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) gcnt <= 0;
        else        gcnt <= gcnt + 1;
    end

    task automatic wait_gate();
        bit hit = 0;
        for (int i = 0; i < Gate + 2; i++) begin
            @(posedge clk);
            #1;
            if (gcnt % Gate == 0) begin
                hit = 1;
                break;
            end
        end
        if (!hit) check_eq("gate_timeout", 32'd0, 32'd1);
    endtask

    // Scoreboard
    typedef struct {
        string       tag;
        int          kind;
        logic [31:0] exp;
    } sb_t;
    sb_t sbq[$];

    task automatic push_exp(input string tag, input int kind, input logic [31:0] exp);
        sb_t e;
        e.tag  = tag;
        e.kind = kind;
        e.exp  = exp;
        sbq.push_back(e);
    endtask

    function automatic logic [31:0] observe(input int kind);
        case (kind)
            0:       return f1;
            1:       return f2;
            2:       return ph;
            3:       return hi;
            default: return lo;
        endcase
    endfunction

    task automatic pop_compare();
        sb_t e;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            check_eq(e.tag, observe(e.kind), e.exp);
        end
    endtask

    // Skip the window the stimulus change lands in, then compare the first full one.
    task automatic gate_case(input string name, input logic [31:0] ef1, input logic [31:0] ef2,
                             input logic [31:0] eph, input logic [31:0] ehi,
                             input logic [31:0] elo);
        push_exp({name, ".f1"}, 0, ef1);
        push_exp({name, ".f2"}, 1, ef2);
        push_exp({name, ".ph"}, 2, eph);
        push_exp({name, ".hi"}, 3, ehi);
        push_exp({name, ".lo"}, 4, elo);
        wait_gate();
        wait_gate();
        pop_compare();
    endtask

    task automatic check_all_zero(input string name);
        check_eq({name, ".f1"}, f1, 32'd0);
        check_eq({name, ".f2"}, f2, 32'd0);
        check_eq({name, ".ph"}, ph, 32'd0);
        check_eq({name, ".hi"}, hi, 32'd0);
        check_eq({name, ".lo"}, lo, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        set_sig(1, 10, 5, 0, 0, 10, 0, 0);
        gate_case("in0_only", 100, 0, 0, 0, 1000);
        set_sig(1, 10, 5, 0, 1, 10, 3, 0);
        gate_case("duty3_7", 100, 100, 0, 300, 700);
        set_sig(1, 20, 10, 0, 1, 20, 10, 5);
        gate_case("lag5", 50, 50, 20, 500, 500);
        set_sig(1, 20, 10, 0, 1, 20, 10, 13);
        gate_case("lag13", 50, 50, 52, 500, 500);
        set_sig(1, 20, 10, 0, 1, 20, 10, 1);
        gate_case("lag1", 50, 50, 4, 500, 500);
        set_sig(1, 20, 10, 0, 1, 20, 10, 0);
        gate_case("same", 50, 50, 0, 500, 500);

        // Asynchronous reset mid-gate, then first refresh exactly one window after release.
        set_sig(1, 10, 5, 0, 0, 10, 0, 0);
        repeat (437) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (Gate - 1) @(posedge clk);
        #1;
        check_eq("rst.lo_early", lo, 32'd0);
        push_exp("rst.lo", 4, 1000);
        push_exp("rst.hi", 3, 0);
        push_exp("rst.f2", 1, 0);
        wait_gate();
        pop_compare();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
